// File: rtl/div_iter_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } div_state_t;

    localparam int unsigned DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q  = '1;
    localparam logic [DIV_WIDTH-1:0] DIV_INT_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_iter_if.sv
// go/done request bus between the muldiv issue logic and the divider.
interface div_iter_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             go;
    logic             kill;
    logic             sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output go, kill, sign, dividend, divisor,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  go, kill, sign, dividend, divisor,
        output busy, done, quotient, remainder
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration; kept separate so a radix-4 step can drop in.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_next_o,
    output logic [WIDTH-1:0] q_next_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // The shifted remainder needs WIDTH+1 bits; the extra MSB of diff is the borrow.
    always_comb begin
        rem_sh = {rem_i, q_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, divisor_i};
        if (diff[WIDTH]) begin
            rem_next_o = rem_sh[WIDTH-1:0];
            q_next_o   = {q_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_next_o = diff[WIDTH-1:0];
            q_next_o   = {q_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU with RISC-V special-case results.
module div_iter
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic       clk,
    input  logic       reset_n,
    div_iter_if.slave  bus
);

    localparam int unsigned     CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_Q  = '1;
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i      (rem_q),
        .q_i        (work_q),
        .divisor_i  (dvs_q),
        .rem_next_o (step_rem),
        .q_next_o   (step_q)
    );

    always_comb begin
        dvd_mag = (bus.sign && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
        dvs_mag = (bus.sign && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        work_d  = work_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quot_d  = quot_q;
        remd_d  = remd_q;

        case (state_q)
            IDLE: begin
                if (bus.go && !bus.kill) begin
                    qneg_d = bus.sign & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    rneg_d = bus.sign & bus.dividend[WIDTH-1];
                    if (bus.divisor == '0) begin
                        quot_d  = ZERO_Q;
                        remd_d  = bus.dividend;
                        state_d = DONE;
                    end else if (bus.sign && bus.dividend == INT_MIN && bus.divisor == '1) begin
                        quot_d  = bus.dividend;
                        remd_d  = '0;
                        state_d = DONE;
                    end else begin
                        work_d  = dvd_mag;
                        rem_d   = '0;
                        dvs_d   = dvs_mag;
                        cnt_d   = CNT_LAST;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.kill) begin
                    state_d = IDLE;
                end else begin
                    rem_d  = step_rem;
                    work_d = step_q;
                    if (cnt_q == '0) begin
                        state_d = FIXUP;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            FIXUP: begin
                if (bus.kill) begin
                    state_d = IDLE;
                end else begin
                    quot_d  = qneg_q ? -work_q : work_q;
                    remd_d  = rneg_q ? -rem_q  : rem_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            work_q  <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
        end
    end

    always_comb begin
        bus.busy      = (state_q == CALC) || (state_q == FIXUP);
        bus.done      = (state_q == DONE);
        bus.quotient  = quot_q;
        bus.remainder = remd_q;
    end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: stimulus pushes expected results, a monitor checks each done.
module tb_div_iter;
    import div_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    div_iter_if #(.WIDTH(W)) bus ();

    div_iter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual_q=0x%h actual_r=0x%h expected=no_done",
                         bus.quotient, bus.remainder);
            end else begin
                mon_e = sbq.pop_front();
                check({mon_e.name, "_q"}, bus.quotient, mon_e.q);
                check({mon_e.name, "_r"}, bus.remainder, mon_e.r);
            end
        end
    end

    task automatic drive_go(input logic sgn, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        bus.go       = 1'b1;
        bus.sign     = sgn;
        bus.dividend = dvd;
        bus.divisor  = dvs;
    endtask

    task automatic run_op(input string name, input logic sgn, input logic [W-1:0] dvd,
                          input logic [W-1:0] dvs, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input int exp_lat);
        int lat;
        exp_t e;
        @(negedge clk);
        drive_go(sgn, dvd, dvs);
        e.q = eq; e.r = er; e.name = name;
        sbq.push_back(e);
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) bus.go = 1'b0;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        bus.go = 1'b0;
        check({name, "_lat"}, W'(lat), W'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   busy_err;
        exp_t e;

        reset_n      = 1'b0;
        bus.go       = 1'b0;
        bus.kill     = 1'b0;
        bus.sign     = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", W'(bus.busy), '0);
        check("reset_done", W'(bus.done), '0);
        check("reset_q", bus.quotient, '0);
        check("reset_r", bus.remainder, '0);
        reset_n = 1'b1;

        // DIVU 100/7 with busy window, stray go pulses and changing operands
        @(negedge clk);
        drive_go(1'b0, 32'd100, 32'd7);
        e.q = 32'd14; e.r = 32'd2; e.name = "divu_100_7";
        sbq.push_back(e);
        lat = 0;
        busy_err = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            bus.go = (k == 5 || k == 20);
            bus.dividend = 32'd999 + W'(k);
            bus.divisor  = 32'd1;
            if (bus.busy !== (k <= 33)) busy_err++;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        bus.go = 1'b0;
        check("divu_100_7_lat", W'(lat), 32'd34);
        check("busy_window_errors", W'(busy_err), '0);
        repeat (3) @(negedge clk);
        check("hold_q", bus.quotient, 32'd14);
        check("hold_r", bus.remainder, 32'd2);

        // kill mid-CALC: no done, previous results kept
        @(negedge clk);
        drive_go(1'b0, 32'd1000, 32'd3);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus.go = 1'b0;
        end
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_busy", W'(bus.busy), '0);
        repeat (40) @(negedge clk);
        check("kill_hold_q", bus.quotient, 32'd14);
        check("kill_hold_r", bus.remainder, 32'd2);

        // kill in IDLE blocks a simultaneous go
        @(negedge clk);
        drive_go(1'b0, 32'd9, 32'd0);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.go   = 1'b0;
        bus.kill = 1'b0;
        check("kill_idle_busy", W'(bus.busy), '0);
        check("kill_idle_done", W'(bus.done), '0);
        check("kill_idle_q", bus.quotient, 32'd14);

        run_op("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
        run_op("div_7_m2",   1'b1, 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1,         34);
        run_op("div_m100_m7",1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 34);
        run_op("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         1);
        run_op("div_m7_0",   1'b1, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 1);
        run_op("divu_max",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         32'h0,         34);
        run_op("divu_3_min", 1'b0, 32'h3,         32'h8000_0000, 32'h0,         32'h3,         34);
        run_op("divu_min_m1",1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 34);
        run_op("divu_wide",  1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1,         32'h7FFF_FFFE, 34);
        run_op("divu_5_0",   1'b0, 32'h5,         32'h0,         32'hFFFF_FFFF, 32'h5,         1);

        // kill while DONE is visible: done already seen, FSM back to IDLE
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_done_busy", W'(bus.busy), '0);
        check("kill_done_done", W'(bus.done), '0);
        check("kill_done_q", bus.quotient, 32'hFFFF_FFFF);

        // async reset in the middle of an op
        @(negedge clk);
        drive_go(1'b0, 32'd1000, 32'd3);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) bus.go = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", W'(bus.busy), '0);
        check("rst_mid_done", W'(bus.done), '0);
        check("rst_mid_q", bus.quotient, '0);
        check("rst_mid_r", bus.remainder, '0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("divu_after_rst", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 34);

        repeat (5) @(negedge clk);
        check("scoreboard_left", W'(sbq.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
